// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI arbiter: FSM state encoding and a width helper.
package spi_arb_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_WAIT  = ST_WAIT,
      S_GAP   = ST_GAP,
      S_HOLD  = ST_HOLD
   } state_t;

   // Ceiling log2, never below 1 so that counters/indices keep a real width.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int j;

   // Scan from the farthest offset down so the nearest hit to ptr wins last.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = IW'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPI master among NREQ requesters with per-slave selects.
// Optional burst mode (ss_n held across words until req_last) under macro SPI_ARB_BURST_EN.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DW       = 8,
   parameter int IDLE_GAP = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_last,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rx_data,
   output logic               m_start,
   output logic [DW-1:0]      m_tx,
   input  logic               m_done,
   input  logic [DW-1:0]      m_rx,
   output logic [NREQ-1:0]    ss_n
);

   localparam int IW = clog2(NREQ);
   localparam int GW = clog2(IDLE_GAP + 1);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win;
   logic [GW-1:0]   gap_cnt;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

`ifdef SPI_ARB_BURST_EN
   logic            last;
`else
   logic            unused_last;
   assign unused_last = ^req_last;
`endif

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_win_oh
      assign win_oh[gi] = (win == IW'(gi));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         win       <= '0;
         gap_cnt   <= '0;
         ss_n      <= '1;
         ack       <= '0;
         rsp_valid <= '0;
         m_start   <= 1'b0;
         m_tx      <= '0;
         rx_data   <= '0;
`ifdef SPI_ARB_BURST_EN
         last      <= 1'b1;
`endif
      end else begin
         ack       <= '0;
         rsp_valid <= '0;
         m_start   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  win     <= pick_idx;
                  m_tx    <= req_data[pick_idx*DW +: DW];
                  ack     <= pick_grant;
                  ss_n    <= ~pick_grant;
                  m_start <= 1'b1;
                  state   <= S_START;
`ifdef SPI_ARB_BURST_EN
                  last    <= req_last[pick_idx];
`endif
               end
            end
            S_START: state <= S_WAIT;
            S_WAIT: begin
               if (m_done) begin
                  rx_data   <= m_rx;
                  rsp_valid <= win_oh;
                  ptr       <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef SPI_ARB_BURST_EN
                  if (!last) state <= S_HOLD;
                  else
`endif
                  begin
                     ss_n <= '1;
                     if (IDLE_GAP > 0) begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(IDLE_GAP);
                     end else begin
                        state   <= S_IDLE;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt <= GW'(1)) state <= S_IDLE;
               else gap_cnt <= gap_cnt - 1'b1;
            end
`ifdef SPI_ARB_BURST_EN
            // Slave stays selected; only the burst owner can continue.
            S_HOLD: begin
               if (req[win]) begin
                  m_tx    <= req_data[win*DW +: DW];
                  last    <= req_last[win];
                  ack     <= win_oh;
                  m_start <= 1'b1;
                  state   <= S_START;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
